// File: rtl/sw_alloc_credit_sched.sv
// sw_alloc_credit_sched: separable input-first switch allocator with round-robin arbiters
// and per-network-output downstream credit tracking; grants are registered (1-cycle latency).
module sw_alloc_credit_sched #(
  parameter int NUM_PORTS   = 5,
  parameter int NUM_VC      = 4,
  parameter int MAX_CREDITS = 8,
  parameter int VC_BITS     = $clog2(NUM_VC),
  parameter int CNT_BITS    = $clog2(MAX_CREDITS + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_PORTS*NUM_VC-1:0]                  vc_req,
  input  logic [NUM_PORTS*NUM_VC-1:0][NUM_PORTS-1:0]   vc_dst_port,
  input  logic [NUM_PORTS-2:0]                         dwnstr_router_increment,
  output logic [NUM_PORTS-1:0]                         sa_grant_valid,
  output logic [NUM_PORTS-1:0][VC_BITS-1:0]            sa_grant_vc,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          sa_allocated_ports,
  output logic [NUM_PORTS-2:0][CNT_BITS-1:0]           credit_count
);
  localparam int PB = $clog2(NUM_PORTS);
  localparam int NV = NUM_PORTS * NUM_VC;

  logic [NUM_PORTS-1:0][VC_BITS-1:0]   ptr_in;
  logic [NUM_PORTS-1:0][PB-1:0]        ptr_out;
  logic [NV-1:0]                       elig;
  logic [NUM_PORTS-2:0]                empty;
  logic [NUM_PORTS-1:0]                s1_valid, g_valid, out_taken;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   s1_vc;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s1_dst, g_port;
  logic [NUM_PORTS-1:0][PB-1:0]        g_src;

  always_comb begin
    for (int o = 0; o < NUM_PORTS - 1; o++) empty[o] = credit_count[o] == '0;
    for (int k = 0; k < NV; k++)
      elig[k] = vc_req[k] && $onehot(vc_dst_port[k]) && !(|(vc_dst_port[k][NUM_PORTS-2:0] & empty));
  end

  // Arbiters scan from lowest to highest priority so the highest-priority match is written last.
  always_comb begin
    int v;
    v = 0;
    s1_valid = '0;
    s1_vc = '0;
    s1_dst = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int n = NUM_VC - 1; n >= 0; n--) begin
        v = (int'(ptr_in[i]) + n) % NUM_VC;
        if (elig[i*NUM_VC+v]) begin
          s1_valid[i] = 1'b1;
          s1_vc[i] = VC_BITS'(v);
          s1_dst[i] = vc_dst_port[i*NUM_VC+v];
        end
      end
  end

  always_comb begin
    int u;
    u = 0;
    out_taken = '0;
    g_src = '0;
    g_valid = '0;
    g_port = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int n = NUM_PORTS - 1; n >= 0; n--) begin
        u = (int'(ptr_out[o]) + n) % NUM_PORTS;
        if (s1_valid[u] && s1_dst[u][o]) begin
          out_taken[o] = 1'b1;
          g_src[o] = PB'(u);
        end
      end
    for (int o = 0; o < NUM_PORTS; o++)
      if (out_taken[o]) begin
        g_valid[g_src[o]] = 1'b1;
        g_port[g_src[o]][o] = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa_grant_valid <= '0;
      sa_grant_vc <= '0;
      sa_allocated_ports <= '0;
      ptr_in <= '0;
      ptr_out <= '0;
      for (int o = 0; o < NUM_PORTS - 1; o++) credit_count[o] <= CNT_BITS'(MAX_CREDITS);
    end else begin
      sa_grant_valid <= g_valid;
      sa_allocated_ports <= g_port;
      for (int i = 0; i < NUM_PORTS; i++) begin
        sa_grant_vc[i] <= g_valid[i] ? s1_vc[i] : '0;
        if (g_valid[i]) ptr_in[i] <= VC_BITS'((int'(s1_vc[i]) + 1) % NUM_VC);
      end
      for (int o = 0; o < NUM_PORTS; o++)
        if (out_taken[o]) ptr_out[o] <= PB'((int'(g_src[o]) + 1) % NUM_PORTS);
      for (int o = 0; o < NUM_PORTS - 1; o++)
        if (out_taken[o] && !dwnstr_router_increment[o])
          credit_count[o] <= credit_count[o] - CNT_BITS'(1);
        else if (!out_taken[o] && dwnstr_router_increment[o] && credit_count[o] != CNT_BITS'(MAX_CREDITS))
          credit_count[o] <= credit_count[o] + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_sw_alloc_credit_sched.sv
// tb_sw_alloc_credit_sched: directed vectors with hand-computed grants and credit counts.
module tb_sw_alloc_credit_sched;
  logic               clk = 1'b0;
  logic               reset;
  logic [19:0]        vc_req;
  logic [19:0][4:0]   vc_dst_port;
  logic [3:0]         inc;
  logic [4:0]         sa_grant_valid;
  logic [4:0][1:0]    sa_grant_vc;
  logic [4:0][4:0]    sa_allocated_ports;
  logic [3:0][3:0]    credit_count;
  int tests = 0, failed = 0;
  int exp_p[6] = '{0, 2, 3, 0, 2, 3};

  sw_alloc_credit_sched dut (
    .clk(clk), .reset(reset), .vc_req(vc_req), .vc_dst_port(vc_dst_port),
    .dwnstr_router_increment(inc), .sa_grant_valid(sa_grant_valid),
    .sa_grant_vc(sa_grant_vc), .sa_allocated_ports(sa_allocated_ports),
    .credit_count(credit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    vc_req = '0;
    vc_dst_port = '0;
    inc = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear();
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", sa_grant_valid, 0);
    check("rst_vc", sa_grant_vc, 0);
    check("rst_ports", sa_allocated_ports, 0);
    check("rst_credit", credit_count, 16'h8888);
    // single request
    vc_req[2] = 1'b1;
    vc_dst_port[2] = 5'b00010;
    step();
    check("t1_valid", sa_grant_valid, 5'b00001);
    check("t1_vc", sa_grant_vc[0], 2);
    check("t1_port", sa_allocated_ports[0], 5'b00010);
    check("t1_credit", credit_count[1], 7);
    clear();
    inc[1] = 1'b1;
    step();
    check("t1_return", credit_count[1], 8);
    check("t1_idle", sa_grant_valid, 0);
    // non-one-hot destinations are ignored
    clear();
    vc_req[4] = 1'b1;
    vc_dst_port[4] = 5'b00110;
    vc_req[9] = 1'b1;
    step();
    check("multi_hot", sa_grant_valid, 0);
    // output contention with credit return every cycle
    do_reset();
    vc_req[0] = 1'b1;
    vc_req[8] = 1'b1;
    vc_req[12] = 1'b1;
    vc_dst_port[0] = 5'b00010;
    vc_dst_port[8] = 5'b00010;
    vc_dst_port[12] = 5'b00010;
    inc[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_valid", sa_grant_valid, 32'(1) << exp_p[k]);
      check("rr_port", sa_allocated_ports[exp_p[k]], 5'b00010);
      check("rr_credit", credit_count[1], 8);
    end
    // credit exhaustion
    do_reset();
    vc_req[0] = 1'b1;
    vc_dst_port[0] = 5'b00100;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("drain_valid", sa_grant_valid, 5'b00001);
      check("drain_credit", credit_count[2], 8 - k);
    end
    step();
    check("empty_block", sa_grant_valid, 0);
    check("empty_credit", credit_count[2], 0);
    inc[2] = 1'b1;
    step();
    inc = '0;
    check("refill_valid", sa_grant_valid, 0);
    check("refill_credit", credit_count[2], 1);
    step();
    check("regrant_valid", sa_grant_valid, 5'b00001);
    check("regrant_credit", credit_count[2], 0);
    step();
    check("reblock_valid", sa_grant_valid, 0);
    check("reblock_credit", credit_count[2], 0);
    // grant and increment together; saturation
    do_reset();
    vc_req[0] = 1'b1;
    vc_dst_port[0] = 5'b01000;
    repeat (3) step();
    check("cnt5", credit_count[3], 5);
    inc[3] = 1'b1;
    step();
    check("both_valid", sa_grant_valid, 5'b00001);
    check("both_credit", credit_count[3], 5);
    clear();
    inc[0] = 1'b1;
    step();
    check("sat_credit", credit_count[0], 8);
    check("hold_credit", credit_count[3], 5);
    // local output is never credit-blocked
    do_reset();
    for (int k = 4; k < 8; k++) begin
      vc_req[k] = 1'b1;
      vc_dst_port[k] = 5'b10000;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      check("local_valid", sa_grant_valid, 5'b00010);
      check("local_vc", sa_grant_vc[1], k % 4);
      check("local_port", sa_allocated_ports[1], 5'b10000);
    end
    check("local_credit", credit_count, 16'h8888);
    // reset in the middle of contention
    do_reset();
    vc_req[1] = 1'b1;
    vc_req[2] = 1'b1;
    vc_req[11] = 1'b1;
    vc_dst_port[1] = 5'b00001;
    vc_dst_port[2] = 5'b00001;
    vc_dst_port[11] = 5'b00001;
    inc[0] = 1'b1;
    step();
    check("mid_valid0", sa_grant_valid, 5'b00001);
    check("mid_vc0", sa_grant_vc[0], 1);
    step();
    check("mid_valid1", sa_grant_valid, 5'b00100);
    check("mid_vc1", sa_grant_vc[2], 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", sa_grant_valid, 0);
    check("mid_rst_credit", credit_count, 16'h8888);
    step();
    check("post_valid", sa_grant_valid, 5'b00001);
    check("post_vc", sa_grant_vc[0], 1);
    check("post_credit", credit_count[0], 8);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
